mips_seq_alu: RTL and testbench

//  Execute-stage ALU fed directly by the ALU-control decoder's 4-bit AluS select.

---
 rtl/mips_seq_alu.sv | 165 ++++++++++++++++
 tb/tb_mips_seq_alu.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_seq_alu.sv
// Execute-stage ALU: single-cycle AND/OR/ADD/SUB/SLT plus an iterative signed
// shift-add MULT (W+2 edges, HI/LO). Define ALU_OVF_EN to add the ovf output.
module mips_seq_alu #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_in,
    output logic         ready_in,
    input  logic [3:0]   AluS,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] result,
    output logic [W-1:0] hi,
    output logic         zero,
    output logic         valid_out
`ifdef ALU_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULT = 4'b0011;
    localparam int         CW      = $clog2(W) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_FIX
    } state_t;

    state_t          state_reg;
    logic [2*W-1:0]  mcand_reg;
    logic [W:0]      mplier_reg;
    logic [2*W-1:0]  prod_reg;
    logic            sign_reg;
    logic [CW-1:0]   count_reg;
    logic [W-1:0]    result_reg;
    logic [W-1:0]    hi_reg;
    logic            zero_reg;
    logic            valid_out_reg;

    logic [W-1:0]    sum_next;
    logic [W-1:0]    diff_next;
    logic [W-1:0]    alu_next;
    logic [W:0]      a_ext;
    logic [W:0]      b_ext;
    logic [W:0]      a_mag;
    logic [W:0]      b_mag;
    logic [2*W-1:0]  prod_fix;

    assign sum_next  = A + B;
    assign diff_next = A - B;

    always_comb begin
        alu_next = '0;
        case (AluS)
            OP_AND:  alu_next = A & B;
            OP_OR:   alu_next = A | B;
            OP_ADD:  alu_next = sum_next;
            OP_SUB:  alu_next = diff_next;
            OP_SLT:  alu_next = {{(W-1){1'b0}}, ($signed(A) < $signed(B))};
            default: alu_next = '0;
        endcase
    end

    // Magnitudes carry one extra bit so the most-negative operand negates cleanly.
    assign a_ext    = {A[W-1], A};
    assign b_ext    = {B[W-1], B};
    assign a_mag    = A[W-1] ? (~a_ext + 1'b1) : a_ext;
    assign b_mag    = B[W-1] ? (~b_ext + 1'b1) : b_ext;
    assign prod_fix = sign_reg ? (~prod_reg + 1'b1) : prod_reg;

`ifdef ALU_OVF_EN
    logic ovf_reg;
    logic ovf_next;

    always_comb begin
        ovf_next = 1'b0;
        case (AluS)
            OP_ADD:  ovf_next = (A[W-1] == B[W-1]) && (sum_next[W-1] != A[W-1]);
            OP_SUB:  ovf_next = (A[W-1] != B[W-1]) && (diff_next[W-1] != A[W-1]);
            default: ovf_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (state_reg == S_IDLE && valid_in && AluS != OP_MULT) begin
            ovf_reg <= ovf_next;
        end else if (state_reg == S_FIX) begin
            ovf_reg <= 1'b0;
        end
    end

    assign ovf = ovf_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            prod_reg      <= '0;
            sign_reg      <= 1'b0;
            count_reg     <= '0;
            result_reg    <= '0;
            hi_reg        <= '0;
            zero_reg      <= 1'b1;
            valid_out_reg <= 1'b0;
        end else begin
            valid_out_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (valid_in) begin
                        if (AluS == OP_MULT) begin
                            mcand_reg  <= {{(W-1){1'b0}}, a_mag};
                            mplier_reg <= b_mag;
                            sign_reg   <= A[W-1] ^ B[W-1];
                            prod_reg   <= '0;
                            count_reg  <= '0;
                            state_reg  <= S_MUL;
                        end else begin
                            result_reg    <= alu_next;
                            zero_reg      <= (alu_next == '0);
                            valid_out_reg <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    if (mplier_reg[0]) begin
                        prod_reg <= prod_reg + mcand_reg;
                    end
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    count_reg  <= count_reg + 1'b1;
                    if (count_reg == CW'(W - 1)) begin
                        state_reg <= S_FIX;
                    end
                end
                S_FIX: begin
                    hi_reg        <= prod_fix[2*W-1:W];
                    result_reg    <= prod_fix[W-1:0];
                    zero_reg      <= (prod_fix[W-1:0] == '0);
                    valid_out_reg <= 1'b1;
                    state_reg     <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign ready_in  = (state_reg == S_IDLE);
    assign result    = result_reg;
    assign hi        = hi_reg;
    assign zero      = zero_reg;
    assign valid_out = valid_out_reg;

endmodule

// File: tb/tb_mips_seq_alu.sv
// Self-checking bench for mips_seq_alu: vector table, MULT corner sequences,
// mid-multiply reset and randomized ops against a plain-arithmetic model.
module tb_mips_seq_alu;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULT = 4'b0011;
    localparam longint     MAXS    = 64'sd2147483647;
    localparam longint     MINS    = -64'sd2147483648;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic        ready_in;
    logic [3:0]  AluS;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] result;
    logic [31:0] hi;
    logic        zero;
    logic        valid_out;
`ifdef ALU_OVF_EN
    logic        ovf;
`endif

    mips_seq_alu #(.W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .AluS      (AluS),
        .A         (A),
        .B         (B),
        .result    (result),
        .hi        (hi),
        .zero      (zero),
        .valid_out (valid_out)
`ifdef ALU_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec;
    int          n_fail;
    logic [31:0] model_hi;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: signed arithmetic in 64 bits, results taken modulo 2^32.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic o);
        longint sa;
        longint sb;
        longint t;
        sa = $signed(a);
        sb = $signed(b);
        o  = 1'b0;
        r  = 32'd0;
        case (op)
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_ADD: begin t = sa + sb; r = t[31:0]; o = (t > MAXS) || (t < MINS); end
            OP_SUB: begin t = sa - sb; r = t[31:0]; o = (t > MAXS) || (t < MINS); end
            OP_SLT: r = (sa < sb) ? 32'd1 : 32'd0;
            OP_MULT: begin t = sa * sb; r = t[31:0]; model_hi = t[63:32]; end
            default: r = 32'd0;
        endcase
    endtask

    // Called at a negedge; returns at the negedge where valid_out is seen.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        AluS     = op;
        A        = a;
        B        = b;
        valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        lat      = 1;
        while (!valid_out && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_op(input string name, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er;
        logic        eo;
        int          lat;
        model(op, a, b, er, eo);
        run_op(op, a, b, lat);
        chk({name, " latency"}, 64'(lat), (op == OP_MULT) ? 64'd34 : 64'd1);
        chk({name, " result"}, {32'd0, result}, {32'd0, er});
        chk({name, " zero"}, {63'd0, zero}, {63'd0, (er == 32'd0)});
        chk({name, " hi"}, {32'd0, hi}, {32'd0, model_hi});
        chk({name, " ready"}, {63'd0, ready_in}, 64'd1);
`ifdef ALU_OVF_EN
        chk({name, " ovf"}, {63'd0, ovf}, {63'd0, eo});
`endif
    endtask

    initial begin
        int          low;
        int          vbad;
        int          lat;
        logic [3:0]  op;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [3:0]  ops[7];

        n_vec    = 0;
        n_fail   = 0;
        model_hi = 32'd0;
        rst_n    = 1'b0;
        valid_in = 1'b0;
        AluS     = 4'd0;
        A        = 32'd0;
        B        = 32'd0;

        tbl[0] = '{OP_ADD, 32'd5, 32'd7, 32'd12, 1'b0};
        tbl[1] = '{OP_SUB, 32'd7, 32'd7, 32'd0, 1'b1};
        tbl[2] = '{OP_SLT, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0};
        tbl[3] = '{OP_SLT, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b1};
        tbl[4] = '{OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0};
        tbl[5] = '{OP_OR,  32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 1'b0};
        tbl[6] = '{OP_SUB, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0};
        tbl[7] = '{4'b1111, 32'h1234_5678, 32'h1, 32'd0, 1'b1};

        repeat (2) @(negedge clk);
        chk("reset ready", {63'd0, ready_in}, 64'd1);
        chk("reset result", {32'd0, result}, 64'd0);
        chk("reset hi", {32'd0, hi}, 64'd0);
        chk("reset zero", {63'd0, zero}, 64'd1);
        chk("reset valid_out", {63'd0, valid_out}, 64'd0);
`ifdef ALU_OVF_EN
        chk("reset ovf", {63'd0, ovf}, 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Table applied back-to-back: valid_out must stay high throughout.
        AluS = tbl[0].op; A = tbl[0].a; B = tbl[0].b; valid_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("tbl%0d valid_out", i), {63'd0, valid_out}, 64'd1);
            chk($sformatf("tbl%0d result", i), {32'd0, result}, {32'd0, tbl[i].res});
            chk($sformatf("tbl%0d zero", i), {63'd0, zero}, {63'd0, tbl[i].z});
            chk($sformatf("tbl%0d ready", i), {63'd0, ready_in}, 64'd1);
            chk($sformatf("tbl%0d hi", i), {32'd0, hi}, 64'd0);
            if (i < 7) begin
                AluS = tbl[i+1].op; A = tbl[i+1].a; B = tbl[i+1].b;
            end else begin
                valid_in = 1'b0;
            end
        end
        @(negedge clk);
        chk("tbl pulse end", {63'd0, valid_out}, 64'd0);

        // MULT -3*4 with an ADD offered (and ignored) during the stall.
        AluS = OP_MULT; A = 32'hFFFFFFFD; B = 32'd4; valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        low      = 0;
        vbad     = 0;
        for (int c = 0; c < 100 && !ready_in; c++) begin
            low++;
            if (valid_out) vbad++;
            if (low == 3) begin
                valid_in = 1'b1; AluS = OP_ADD; A = 32'd100; B = 32'd100;
            end
            if (low == 6) valid_in = 1'b0;
            @(negedge clk);
        end
        chk("mult stall cycles", 64'(low), 64'd33);
        chk("mult stall valid_out", 64'(vbad), 64'd0);
        chk("mult valid_out", {63'd0, valid_out}, 64'd1);
        chk("mult result", {32'd0, result}, 64'hFFFFFFF4);
        chk("mult hi", {32'd0, hi}, 64'hFFFFFFFF);
        chk("mult zero", {63'd0, zero}, 64'd0);
        model_hi = 32'hFFFFFFFF;
        @(negedge clk);
        chk("mult pulse end", {63'd0, valid_out}, 64'd0);
        chk("stall add ignored", {32'd0, result}, 64'hFFFFFFF4);

        // Most-negative operands, then an ADD that must not disturb hi.
        run_op(OP_MULT, 32'h80000000, 32'h80000000, lat);
        chk("minmult latency", 64'(lat), 64'd34);
        chk("minmult hi", {32'd0, hi}, 64'h40000000);
        chk("minmult result", {32'd0, result}, 64'd0);
        chk("minmult zero", {63'd0, zero}, 64'd1);
        model_hi = 32'h40000000;
        run_op(OP_ADD, 32'd1, 32'd1, lat);
        chk("add after mult result", {32'd0, result}, 64'd2);
        chk("add after mult hi", {32'd0, hi}, 64'h40000000);

`ifdef ALU_OVF_EN
        run_op(OP_ADD, 32'h7FFFFFFF, 32'd1, lat);
        chk("ovf add result", {32'd0, result}, 64'h80000000);
        chk("ovf add flag", {63'd0, ovf}, 64'd1);
        run_op(OP_ADD, 32'd1, 32'd1, lat);
        chk("ovf clear flag", {63'd0, ovf}, 64'd0);
`endif

        // Asynchronous reset ten cycles into a multiply.
        AluS = OP_MULT; A = 32'd12345; B = 32'd678; valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre-reset busy", {63'd0, ready_in}, 64'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset ready", {63'd0, ready_in}, 64'd1);
        chk("midreset result", {32'd0, result}, 64'd0);
        chk("midreset zero", {63'd0, zero}, 64'd1);
        chk("midreset valid_out", {63'd0, valid_out}, 64'd0);
        chk("midreset hi", {32'd0, hi}, 64'd0);
        model_hi = 32'd0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_op("post-reset add", OP_ADD, 32'd2, 32'd3);

        // Randomized ops against the reference model.
        ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_MULT, 4'b1010};
        for (int i = 0; i < 200; i++) begin
            op = ops[$urandom_range(6, 0)];
            if (op == OP_MULT && $urandom_range(3, 0) != 0) op = OP_ADD;
            ra = $urandom();
            rb = $urandom();
            case ($urandom_range(7, 0))
                0: ra = 32'h80000000;
                1: rb = 32'h7FFFFFFF;
                2: rb = ra;
                3: ra = 32'd0;
                default: ;
            endcase
            check_op($sformatf("rnd%0d op%0h", i, op), op, ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
